// File: rtl/iter_mul.sv
// rtl/iter_mul.sv - iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned
// Optional build macro: MUL_EARLY_OUT_EN (finish as soon as the remaining multiplier bits are all zero)
`timescale 1ns/1ps

module iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             mul,
  input  logic             mul_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             choke,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             complete,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic             neg_q,    neg_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;

  logic             accept;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_shifted;
  logic             last_iter;
  logic [PW-1:0]    product;

  // Datapath helpers: operand magnitudes, one shift-add step and the signed fix-up
  always_comb begin
    accept         = mul && !choke;
    // The most negative value negates to itself, which is exactly its unsigned magnitude
    x_mag          = (mul_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    y_mag          = (mul_signed && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
    acc_sum        = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shifted = mplier_q >> 1;
`ifdef MUL_EARLY_OUT_EN
    // Once no multiplier bits remain, further iterations cannot change the sum
    last_iter      = (count_q == CW'(WIDTH - 1)) || (mplier_shifted == '0);
`else
    last_iter      = (count_q == CW'(WIDTH - 1));
`endif
    product        = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
  end

  // Next-state and output decode for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, x_mag};
          mplier_d = y_mag;
          neg_d    = mul_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (choke) begin
          // Abort: the previous product stays visible on hi/lo
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shifted;
          count_d  = count_q + CW'(1);
          if (last_iter) begin
            {hi_d, lo_d} = product;
            state_d      = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Result already committed; a held request is only taken back in IDLE
        complete = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_iter_mul.sv
// tb/tb_iter_mul.sv - self-checking bench for iter_mul with a transaction-level reference model
`timescale 1ns/1ps

module tb_iter_mul;

  logic        mul_clk = 1'b0;
  logic        reset = 1'b1;
  logic        mul = 1'b0;
  logic        mul_signed = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        choke = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        complete;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  iter_mul #(.WIDTH(32)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .mul        (mul),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .choke      (choke),
    .hi         (hi),
    .lo         (lo),
    .complete   (complete),
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  // Reference: full-width arithmetic product
  function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (s) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Reference: cycles from accept edge to the complete cycle
  function automatic int op_latency(input logic s, input logic [31:0] b);
    logic [31:0] mag;
    int          hb;
    mag = (s && b[31]) ? (~b + 32'd1) : b;
    hb  = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i + 1;
`ifdef MUL_EARLY_OUT_EN
    return 1 + ((hb < 1) ? 1 : hb);
`else
    return 33 + 0 * hb;
`endif
  endfunction

  // Transaction model: m_left counts the busy cycles still owed, 1 = the complete cycle
  int          m_left = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left == 0) begin
      if (mul && !choke) begin
        m_left <= op_latency(mul_signed, y);
        m_res  <= ref_product(mul_signed, x, y);
      end
    end else if (m_left == 1) begin
      m_left <= 0;
    end else if (choke) begin
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge mul_clk) begin
    if (cmp_en) begin
      chk("cyc_hi",       64'(hi),       64'(m_hi));
      chk("cyc_lo",       64'(lo),       64'(m_lo));
      chk("cyc_busy",     64'(busy),     64'(m_left != 0));
      chk("cyc_complete", 64'(complete), 64'(m_left == 1));
    end
  end

  task automatic wait_complete(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge mul_clk);
      if (complete) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL complete_timeout: no complete within 100 cycles at %0t", $time);
    end
  endtask

  // Single-cycle request, scrambles operands during RUN, returns cycles to complete
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(posedge mul_clk); #1;
    mul = 1'b1; mul_signed = s; x = a; y = b;
    @(posedge mul_clk); #1;
    mul = 1'b0; mul_signed = 1'($urandom); x = $urandom; y = $urandom;
    wait_complete(lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int pulses;

    repeat (3) @(posedge mul_clk);
    #1;
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Model pinned by hand-computed products
    chk("ref_minmin", ref_product(1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    chk("ref_umax",   ref_product(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref_neg3x7", ref_product(1'b1, 32'hFFFF_FFFD, 32'h0000_0007), 64'hFFFF_FFFF_FFFF_FFEB);

    @(negedge mul_clk);
    chk("rst_hi",       64'(hi),       64'd0);
    chk("rst_lo",       64'(lo),       64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_complete", 64'(complete), 64'd0);

    // Unsigned max, complete exactly one cycle
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("umax_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("umax_lo", 64'(lo), 64'h0000_0001);
`ifndef MUL_EARLY_OUT_EN
    chk("umax_lat", 64'(lat), 64'd33);
`endif
    @(negedge mul_clk);
    chk("umax_pulse_len", 64'(complete), 64'd0);

    // Reset during RUN
    @(posedge mul_clk); #1;
    mul = 1'b1; mul_signed = 1'b0; x = 32'd3; y = 32'd5;
    @(posedge mul_clk); #1;
    mul = 1'b0;
    repeat (9) @(posedge mul_clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rrun_hi",       64'(hi),       64'd0);
    chk("rrun_lo",       64'(lo),       64'd0);
    chk("rrun_busy",     64'(busy),     64'd0);
    chk("rrun_complete", 64'(complete), 64'd0);
    @(posedge mul_clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge mul_clk);
      if (complete) pulses++;
    end
    chk("rrun_no_complete", 64'(pulses), 64'd0);
    do_op(1'b0, 32'd3, 32'd5, lat);
    chk("rrun_again_hi", 64'(hi), 64'd0);
    chk("rrun_again_lo", 64'(lo), 64'd15);
    chk("rrun_again_lat", 64'(lat), 64'(op_latency(1'b0, 32'd5)));

    // Signed mixes
    do_op(1'b1, 32'h8000_0000, 32'd1, lat);
    chk("smin_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("smin_lo", 64'(lo), 64'h8000_0000);
    do_op(1'b1, 32'hFFFF_FFFD, 32'd7, lat);
    chk("sneg3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("sneg3_lo", 64'(lo), 64'hFFFF_FFEB);
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat);
    chk("sminmin_hi", 64'(hi), 64'h4000_0000);
    chk("sminmin_lo", 64'(lo), 64'h0000_0000);

    // Choke abort
    do_op(1'b0, 32'd9, 32'd9, lat);
    chk("nine_lo", 64'(lo), 64'd81);
    @(posedge mul_clk); #1;
    mul = 1'b1; mul_signed = 1'b0; x = 32'd6; y = 32'd7;
    @(posedge mul_clk); #1;
    mul = 1'b0;
    repeat (11) @(posedge mul_clk);
    #1;
    choke = 1'b1;
    @(posedge mul_clk); #1;
    choke = 1'b0;
    @(negedge mul_clk);
    chk("choke_busy", 64'(busy), 64'd0);
    chk("choke_hi",   64'(hi),   64'd0);
    chk("choke_lo",   64'(lo),   64'd81);
    pulses = 0;
    repeat (40) begin
      @(negedge mul_clk);
      if (complete) pulses++;
    end
    chk("choke_no_complete", 64'(pulses), 64'd0);

    // choke and mul together in IDLE
    @(posedge mul_clk); #1;
    mul = 1'b1; choke = 1'b1; x = 32'd11; y = 32'd13;
    repeat (3) begin
      @(negedge mul_clk);
      chk("chokemul_busy", 64'(busy), 64'd0);
    end
    @(posedge mul_clk); #1;
    mul = 1'b0; choke = 1'b0;

    // mul held through DONE: back-to-back restart
    @(posedge mul_clk); #1;
    mul = 1'b1; mul_signed = 1'b0; x = 32'd100; y = 32'h0001_0000;
    wait_complete(n);
    chk("b2b_first_lo", 64'(lo), 64'h0064_0000);
    wait_complete(n);
    mul = 1'b0;
`ifndef MUL_EARLY_OUT_EN
    chk("b2b_gap", 64'(n), 64'd34);
`else
    chk("b2b_gap", 64'(n), 64'(op_latency(1'b0, 32'h0001_0000) + 1));
`endif
    @(negedge mul_clk);
    @(negedge mul_clk);
    chk("b2b_no_third", 64'(busy), 64'd0);

`ifdef MUL_EARLY_OUT_EN
    do_op(1'b0, 32'h1234_5678, 32'd0, lat);
    chk("eo_zero_lat", 64'(lat), 64'd2);
    chk("eo_zero_hi",  64'(hi),  64'd0);
    chk("eo_zero_lo",  64'(lo),  64'd0);
    do_op(1'b0, 32'h1234_5678, 32'h10, lat);
    chk("eo_x10_lat", 64'(lat), 64'd6);
    chk("eo_x10_hi",  64'(hi),  64'h1);
    chk("eo_x10_lo",  64'(lo),  64'h2345_6780);
`else
    do_op(1'b0, 32'h1234_5678, 32'd0, lat);
    chk("zero_lat", 64'(lat), 64'd33);
    chk("zero_lo",  64'(lo),  64'd0);
`endif

    // Randomised operations with operand noise and occasional choke
    for (int k = 0; k < 40; k++) begin
      @(posedge mul_clk); #1;
      mul = 1'b1; mul_signed = 1'($urandom); x = pick(); y = pick();
      @(posedge mul_clk); #1;
      mul = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (!busy) break;
        x = $urandom; y = $urandom; mul_signed = 1'($urandom);
        choke = ($urandom_range(0, 49) == 0);
        @(posedge mul_clk); #1;
      end
      choke = 1'b0;
    end
    repeat (3) @(posedge mul_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_mul.md
Name: iter_mul

Overview:
- Iterative radix-2 shift-add multiplier, 32x32 -> 64. Signed or unsigned.
- Counterpart of the iterative divider in the execute-stage multicycle unit. Serves MULT/MULTU and writes HI/LO.
- Uses the same level-request / complete-pulse / choke-flush handshake as the divider, so one stall controller can drive both units.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.

Ports:
- mul_clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mul  in  1  level request; an operation is accepted when state=IDLE and mul=1 and choke=0
- mul_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- x  in  32  multiplicand; sampled at accept
- y  in  32  multiplier; sampled at accept
- choke  in  1  flush/abort from pipeline (exception or cancel)
- hi  out  32  product[63:32]
- lo  out  32  product[31:0]
- complete  out  1  one-cycle pulse: hi/lo hold the new product
- busy  out  1  high in RUN and DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state=IDLE, count=0, hi=0, lo=0, complete=0, busy=0.
  - Internal accumulator and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: on an accept edge:
  - latch |x| into mcand (64-bit, zero-extended) and |y| into mplier (32-bit).
  - Magnitude = two's-complement negate when mul_signed and bit31=1; otherwise the raw value.
  - latch neg = mul_signed & (x[31]^y[31]).
  - clear acc; count=0; go to RUN.
- RUN, each cycle:
  - if mplier[0]: acc <= acc + mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - After the iteration with count=31, go to DONE.
  - The final add result is registered into {hi,lo} on that same edge, negated (64-bit two's complement) if neg.
- DONE: complete=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency: accept at edge T; complete is high in the cycle after edge T+32, i.e. 33 cycles from accept to complete.
- hi/lo change only on the edge entering DONE. Otherwise they hold the last product, including across choke and across a new operation that has not finished.
- mul still high in DONE: not accepted. It is accepted at the first IDLE edge, which is back-to-back restart. The requester must drop mul in the complete cycle to avoid a repeat.
- choke:
  - In RUN or DONE, choke=1 forces IDLE on the next edge. complete stays 0 that cycle if in RUN. hi/lo are not updated.
  - choke and mul both high in IDLE: no accept; choke wins.
  - choke in the DONE cycle: complete is still 1 in that cycle. The result is already committed.
- x/y/mul_signed changes during RUN are ignored.
- Boundary values:
  - 0x80000000 signed: its magnitude is 0x80000000 as unsigned, with no overflow.
  - (-2^31)*(-2^31) = 0x4000000000000000.
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined: in RUN, if the mplier value after the current shift is 0, commit the result and go to DONE on that edge regardless of count.
  - If mplier is 0 at accept, RUN lasts 1 cycle.
  - Latency = 1 + max(1, index of highest set bit of |y| + 1) cycles to complete.
  - Example: y=1 gives complete 2 cycles after accept.
- Undefined: fixed 32 RUN cycles; latency is always 33.
- Results are identical in both builds.

Test Plan:
- Reset in RUN: accept 3*5, assert reset 10 cycles later -> hi=lo=0, busy=0, complete never pulses; next accept of 3*5 -> lo=15, hi=0 at cycle 33.
- Unsigned max: mul_signed=0, x=y=0xFFFFFFFF -> complete at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; complete high exactly one cycle.
- Signed mix: mul_signed=1, x=0x80000000, y=1 -> hi=0xFFFFFFFF, lo=0x80000000. Also x=0xFFFFFFFD (-3), y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Choke abort: accept 6*7, then 9*9 to completion (lo=81); accept 6*7 and assert choke at cycle 12 -> IDLE next edge, no complete, hi/lo remain 0/81.
- choke+mul together in IDLE -> no accept, busy stays 0. mul held through DONE -> second accept at the next edge, second complete 34 cycles after the first.
- With MUL_EARLY_OUT_EN: x=0x12345678, y=0 -> complete 2 cycles after accept, hi=lo=0. y=0x10 -> complete 6 cycles after accept, lo=0x23456780, hi=0x1.
